mm_seq_ctrl: RTL
================

Name: mm_seq_ctrl

Overview:
Sequencer for the matrix-multiply datapath: operand RAM reads → 4 parallel MACs (MU1..MU4, 18-bit) → 4-word write-back burst into the result RAM.
- On a start pulse it runs N_BURST bursts.
- Each burst: K_LEN operand fetches, MAC clear/enable timing, a one-cycle web pulse to the write-back unit, then a hold window while write-back drains.
- Sits between the top-level control FSM and the MAC/write-back datapath; sole owner of web.

Parameters:
K_LEN, 8, accumulation length (operand fetches per burst), ≥2
N_BURST, 4, result groups per job (each = 4 words written back)
WB_LEN, 4, cycles write-back needs after a web pulse; MAC outputs must stay stable throughout
OP_AW, 8, operand RAM address width; must hold N_BURST*K_LEN-1

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset; asynchronous, active-low
start  in  1  job request, sampled only in IDLE
abort  in  1  synchronous abort, any state
op_addr  out  OP_AW  operand RAM read address
coef_addr  out  3  coefficient index (= k)
mac_clr  out  1  MAC loads instead of accumulates, coincident with first mac_en
mac_en  out  1  MAC accumulate enable
web  out  1  write-back start pulse, one cycle
burst_idx  out  2  current burst number
busy  out  1  job in progress
done  out  1  one-cycle completion pulse

Behaviour:
- Reset (async, rst=0): state IDLE; k=0, burst=0. All outputs 0: op_addr, coef_addr, mac_clr, mac_en, web, burst_idx, busy, done.
- States: IDLE, FETCH, DRAIN, WB, WAIT, DONE. All outputs are registered or decoded from registered state only; no input→output combinational path.
- IDLE: start=1 → FETCH with k=0, burst=0. busy=1 from the FETCH cycle onward.
- FETCH (K_LEN cycles):
  - op_addr = burst*K_LEN + k; coef_addr = k; k increments each cycle.
  - On k=K_LEN-1 → DRAIN.
- mac_en:
  - Registered copy of (state==FETCH), matching the 1-cycle RAM read latency.
  - High for K_LEN cycles, starting the cycle after FETCH entry and ending in DRAIN.
  - mac_clr is high only on the first of those cycles.
- DRAIN (1 cycle): last mac_en; op_addr holds its last value. → WB.
- WB (1 cycle): web=1; mac_en=0. → WAIT with wait counter=0.
- WAIT (WB_LEN cycles):
  - mac_en=0 and mac_clr=0, so MAC outputs stay frozen while write-back consumes MU1..MU4.
  - At end: burst<N_BURST-1 → burst+1, k=0, FETCH; otherwise → DONE.
- DONE (1 cycle): done=1, busy=0. → IDLE.
- Timing (start sampled at edge 0, defaults):
  - Burst b: FETCH cycles 1+14b..8+14b, DRAIN 9+14b, web 10+14b, WAIT 11+14b..14+14b.
  - Burst period = K_LEN+2+WB_LEN = 14 cycles.
  - done at cycle 57.
- Boundary conditions:
  - start while busy or in DONE is ignored; a start in the cycle after done is accepted.
  - abort=1 in any state → IDLE next cycle. Counters cleared, mac_en/web forced 0 in that cycle's registered outputs, no done pulse. abort has priority over start.
  - Exactly one web pulse per burst, exactly N_BURST per completed job.
  - burst_idx wraps only via the IDLE restart; never exceeds N_BURST-1.
  - Reset mid-burst: immediate return to IDLE values. A web already pulsed is not repeated.

Decomposition:
- Shared package (mm_pkg): state encoding enum (IDLE..DONE), K_LEN/N_BURST/WB_LEN defaults, result data width 18, RAM address width 8.
- One natural sub-module: mod_counter, a parameterised count-to-N counter with clear, enable and wrap flag. Instantiated three times: k, wait, burst.

Test Plan:
1. Reset then idle: rst low mid-cycle → all outputs 0 asynchronously; start never asserted → no activity for 100 cycles.
2. Full job: start pulse at cycle 0 → op_addr 0..7 on cycles 1-8, mac_clr only at cycle 2, mac_en cycles 2-9, web at 10/24/38/52, op_addr 8..15 on cycles 15-22, done=1 only at cycle 57, busy 1 on cycles 1-56.
3. start held high continuously → jobs back-to-back, second FETCH begins cycle 59, no double web.
4. abort at cycle 20 (burst 1 FETCH) → IDLE at cycle 21, mac_en/web 0, no done, exactly one web seen (cycle 10).
5. Async reset at cycle 12 (WAIT) → outputs 0 immediately; start at cycle 20 → op_addr restarts at 0, burst_idx 0.
6. Parameter variant K_LEN=3, N_BURST=2, WB_LEN=4 → period 9, web at cycles 5 and 14, done at cycle 19.

Source files
------------

// File: rtl/mm_seq_ctrl_pkg.sv
// Shared types and defaults for the matrix-multiply sequencer.
package mm_seq_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDrain,
    StWb,
    StWait,
    StDone
  } state_e;

  localparam int unsigned KLenDef   = 8;
  localparam int unsigned NBurstDef = 4;
  localparam int unsigned WbLenDef  = 4;
  localparam int unsigned DataW     = 18;
  localparam int unsigned OpAwDef   = 8;

  // Counter width for a 0..n-1 counter; never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mm_seq_ctrl_if.sv
// Control/datapath handshake between the top-level FSM and the sequencer.
interface mm_seq_ctrl_if
  import mm_seq_ctrl_pkg::*;
#(
  parameter int unsigned OP_AW = OpAwDef
);
  logic             start;
  logic             abort;
  logic [OP_AW-1:0] op_addr;
  logic [2:0]       coef_addr;
  logic             mac_clr;
  logic             mac_en;
  logic             web;
  logic [1:0]       burst_idx;
  logic             busy;
  logic             done;

  // Top-level control side: requests jobs, observes progress.
  modport master (
    output start, abort,
    input  op_addr, coef_addr, mac_clr, mac_en, web, burst_idx, busy, done
  );

  // Sequencer side.
  modport slave (
    input  start, abort,
    output op_addr, coef_addr, mac_clr, mac_en, web, burst_idx, busy, done
  );
endinterface

// File: rtl/mm_seq_ctrl_counter.sv
// Count 0..N-1 with synchronous clear, enable and a terminal-count flag.
module mm_seq_ctrl_counter
  import mm_seq_ctrl_pkg::*;
#(
  parameter int unsigned N = 8,
  parameter int unsigned W = cnt_w(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clr,
  input  logic         i_en,
  output logic [W-1:0] o_cnt,
  output logic         o_wrap
);
  localparam logic [W-1:0] MaxCnt = W'(N - 1);

  logic [W-1:0] r_cnt;

  // Clear beats enable; an enabled count at N-1 rolls back to zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= (r_cnt == MaxCnt) ? '0 : r_cnt + W'(1);
    end
  end

  assign o_cnt  = r_cnt;
  assign o_wrap = (r_cnt == MaxCnt);

endmodule

// File: rtl/mm_seq_ctrl.sv
// Burst sequencer: operand fetch, MAC clear/enable, write-back pulse and hold.
module mm_seq_ctrl
  import mm_seq_ctrl_pkg::*;
#(
  parameter int unsigned K_LEN   = KLenDef,
  parameter int unsigned N_BURST = NBurstDef,
  parameter int unsigned WB_LEN  = WbLenDef,
  parameter int unsigned OP_AW   = OpAwDef
) (
  input  logic         clk,
  input  logic         rst,
  mm_seq_ctrl_if.slave seq_bus
);
  localparam int unsigned KW = cnt_w(K_LEN);
  localparam int unsigned WW = cnt_w(WB_LEN);
  localparam int unsigned BW = cnt_w(N_BURST);

  state_e           r_state;
  logic [OP_AW-1:0] r_op_addr;
  logic             r_mac_en;
  logic             r_mac_clr;
  logic             r_web;
  logic             r_busy;
  logic             r_done;

  logic [KW-1:0] w_k;
  logic          w_k_wrap;
  logic          w_k_en;
  logic          w_k_zero;
  logic [WW-1:0] w_wait_cnt;
  logic          w_wait_wrap;
  logic          w_wait_en;
  logic [BW-1:0] w_burst;
  logic          w_burst_wrap;
  logic          w_burst_en;
  logic          w_unused_wait_cnt;

  assign w_k_en     = (r_state == StFetch);
  assign w_k_zero   = (w_k == '0);
  assign w_wait_en  = (r_state == StWait);
  // The burst counter wraps to zero after the final burst, ready for restart.
  assign w_burst_en = (r_state == StWait) && w_wait_wrap;

  mm_seq_ctrl_counter #(.N(K_LEN), .W(KW)) u_k_cnt (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (seq_bus.abort),
    .i_en   (w_k_en),
    .o_cnt  (w_k),
    .o_wrap (w_k_wrap)
  );

  mm_seq_ctrl_counter #(.N(WB_LEN), .W(WW)) u_wait_cnt (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (seq_bus.abort),
    .i_en   (w_wait_en),
    .o_cnt  (w_wait_cnt),
    .o_wrap (w_wait_wrap)
  );

  mm_seq_ctrl_counter #(.N(N_BURST), .W(BW)) u_burst_cnt (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (seq_bus.abort),
    .i_en   (w_burst_en),
    .o_cnt  (w_burst),
    .o_wrap (w_burst_wrap)
  );

  // Only the terminal flag of the wait counter drives control.
  assign w_unused_wait_cnt = ^w_wait_cnt;

  // Main FSM with registered outputs. op_addr is kept as a running address:
  // bursts are contiguous, so burst*K_LEN+k is just the previous address + 1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= StIdle;
      r_op_addr <= '0;
      r_mac_en  <= 1'b0;
      r_mac_clr <= 1'b0;
      r_web     <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else if (seq_bus.abort) begin
      r_state   <= StIdle;
      r_op_addr <= '0;
      r_mac_en  <= 1'b0;
      r_mac_clr <= 1'b0;
      r_web     <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      // MAC enable trails FETCH by one cycle to match the RAM read latency.
      r_mac_en  <= (r_state == StFetch);
      r_mac_clr <= (r_state == StFetch) && w_k_zero;
      r_web     <= (r_state == StDrain);
      r_done    <= 1'b0;
      case (r_state)
        StIdle: begin
          if (seq_bus.start) begin
            r_state   <= StFetch;
            r_busy    <= 1'b1;
            r_op_addr <= '0;
          end
        end
        StFetch: begin
          if (w_k_wrap) begin
            r_state <= StDrain;
          end else begin
            r_op_addr <= r_op_addr + OP_AW'(1);
          end
        end
        StDrain: r_state <= StWb;
        StWb:    r_state <= StWait;
        StWait: begin
          if (w_wait_wrap) begin
            if (w_burst_wrap) begin
              r_state   <= StDone;
              r_busy    <= 1'b0;
              r_done    <= 1'b1;
              r_op_addr <= '0;
            end else begin
              r_state   <= StFetch;
              r_op_addr <= r_op_addr + OP_AW'(1);
            end
          end
        end
        StDone:  r_state <= StIdle;
        default: r_state <= StIdle;
      endcase
    end
  end

  assign seq_bus.op_addr   = r_op_addr;
  assign seq_bus.coef_addr = 3'(w_k);
  assign seq_bus.mac_clr   = r_mac_clr;
  assign seq_bus.mac_en    = r_mac_en;
  assign seq_bus.web       = r_web;
  assign seq_bus.burst_idx = 2'(w_burst);
  assign seq_bus.busy      = r_busy;
  assign seq_bus.done      = r_done;

endmodule
